// File: rtl/psum_accum_pkg.sv
// Shared CIM definitions for the partial-sum accumulator slice.
// Holds the default lane geometry, the activation width handed to the next
// layer, the fixed widths of the job configuration fields, and the FSM state
// enum used by psum_accum.
package psum_accum_pkg;

  localparam int CIM_LANES   = 8;
  localparam int CIM_PSUM_W  = 18;
  localparam int CIM_ACC_W   = 24;
  localparam int CIM_ACT_W   = 4;
  localparam int CIM_ACT_MAX = (1 << CIM_ACT_W) - 1;
  localparam int CIM_BIAS_W  = 8;
  localparam int CIM_CFG_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    QUANT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/psum_requant.sv
// Per-lane requantizer: adds the signed 8b bias to the accumulator, applies a
// round-half-up arithmetic right shift and clamps into the unsigned
// activation range 0..CIM_ACT_MAX.
// Ports:
//   acc_i   - signed lane accumulator
//   bias_i  - signed 8b lane bias
//   shift_i - right-shift amount (0 means no rounding and no shift)
//   act_o   - unsigned clamped activation
module psum_requant
  import psum_accum_pkg::*;
#(
  parameter int ACC_W = CIM_ACC_W
) (
  input  logic signed [ACC_W-1:0]      acc_i,
  input  logic signed [CIM_BIAS_W-1:0] bias_i,
  input  logic        [CIM_CFG_W-1:0]  shift_i,
  output logic        [CIM_ACT_W-1:0]  act_o
);

  // Two guard bits so that neither the bias add nor the rounding constant can
  // wrap, even with an accumulator sitting at its extreme value.
  localparam int EXT_W = ACC_W + 2;

  logic signed [EXT_W-1:0] sum;
  logic signed [EXT_W-1:0] rounded;
  logic signed [EXT_W-1:0] shifted;

  // Bias, round half up by adding 2^(shift-1) before the arithmetic shift,
  // then clamp. A zero shift skips the rounding constant entirely.
  always_comb begin
    sum     = EXT_W'(acc_i) + EXT_W'(bias_i);
    rounded = sum;
    if (shift_i != '0) begin
      rounded = sum + (EXT_W'(1) << (shift_i - 4'd1));
    end
    shifted = rounded >>> shift_i;
    if (shifted < 0) begin
      act_o = '0;
    end else if (shifted > EXT_W'(CIM_ACT_MAX)) begin
      act_o = CIM_ACT_W'(CIM_ACT_MAX);
    end else begin
      act_o = shifted[CIM_ACT_W-1:0];
    end
  end

endmodule

// File: rtl/psum_accum.sv
// Partial-sum accumulator: collects num_pass passes of packed signed PSUM
// lanes from the macro array, then requantizes every lane into a 4b unsigned
// activation for the next layer.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - begin a job (ignored while busy)
//   num_pass    - passes per job, 0 means 16 (latched on start)
//   shift       - requant right shift (latched on start)
//   bias_in     - packed signed 8b per-lane bias (latched on start)
//   psum_valid  - psum_in carries one pass this cycle (used only in ACCUM)
//   psum_in     - packed signed PSUM lanes, lane 0 in the LSBs
//   busy        - FSM is not in IDLE
//   out_valid   - one-cycle pulse, act_out holds a fresh result
//   act_out     - packed unsigned activations, lane 0 in the LSBs
module psum_accum
  import psum_accum_pkg::*;
#(
  parameter int LANES  = CIM_LANES,
  parameter int PSUM_W = CIM_PSUM_W,
  parameter int ACC_W  = CIM_ACC_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [CIM_CFG_W-1:0]         num_pass,
  input  logic [CIM_CFG_W-1:0]         shift,
  input  logic [LANES*CIM_BIAS_W-1:0]  bias_in,
  input  logic                         psum_valid,
  input  logic [LANES*PSUM_W-1:0]      psum_in,
  output logic                         busy,
  output logic                         out_valid,
  output logic [LANES*CIM_ACT_W-1:0]   act_out
);

  state_e                        state_q, state_d;
  logic [CIM_CFG_W-1:0]          num_pass_q, num_pass_d;
  logic [CIM_CFG_W-1:0]          shift_q, shift_d;
  logic [LANES*CIM_BIAS_W-1:0]   bias_q, bias_d;
  logic [CIM_CFG_W-1:0]          pass_cnt_q, pass_cnt_d;
  logic signed [ACC_W-1:0]       acc_q [LANES];
  logic signed [ACC_W-1:0]       acc_d [LANES];
  logic [LANES*CIM_ACT_W-1:0]    act_q, act_d;
  logic [LANES*CIM_ACT_W-1:0]    requant_act;

  // One requantizer per lane, working straight off the accumulators so the
  // result is ready to be captured during the single QUANT cycle.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    psum_requant #(
      .ACC_W(ACC_W)
    ) u_requant (
      .acc_i  (acc_q[g]),
      .bias_i (bias_q[g*CIM_BIAS_W +: CIM_BIAS_W]),
      .shift_i(shift_q),
      .act_o  (requant_act[g*CIM_ACT_W +: CIM_ACT_W])
    );
  end

  // Next-state and datapath update. The pass counter is 4 bits wide and the
  // last-pass compare is done modulo 16, so num_pass=0 naturally ends after
  // the sixteenth pass (counter 15 == 0-1). psum_valid and start only matter
  // in the states that own them; everywhere else they fall through untouched.
  always_comb begin
    state_d    = state_q;
    num_pass_d = num_pass_q;
    shift_d    = shift_q;
    bias_d     = bias_q;
    pass_cnt_d = pass_cnt_q;
    acc_d      = acc_q;
    act_d      = act_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          num_pass_d = num_pass;
          shift_d    = shift;
          bias_d     = bias_in;
          pass_cnt_d = '0;
          for (int l = 0; l < LANES; l++) begin
            acc_d[l] = '0;
          end
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (psum_valid) begin
          for (int l = 0; l < LANES; l++) begin
            acc_d[l] = acc_q[l] + ACC_W'($signed(psum_in[l*PSUM_W +: PSUM_W]));
          end
          pass_cnt_d = pass_cnt_q + 4'd1;
          if (pass_cnt_q == num_pass_q - 4'd1) begin
            state_d = QUANT;
          end
        end
      end
      QUANT: begin
        act_d   = requant_act;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any job in flight and clears
  // every piece of state, including the visible activations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      num_pass_q <= '0;
      shift_q    <= '0;
      bias_q     <= '0;
      pass_cnt_q <= '0;
      act_q      <= '0;
      for (int l = 0; l < LANES; l++) begin
        acc_q[l] <= '0;
      end
    end else begin
      state_q    <= state_d;
      num_pass_q <= num_pass_d;
      shift_q    <= shift_d;
      bias_q     <= bias_d;
      pass_cnt_q <= pass_cnt_d;
      act_q      <= act_d;
      for (int l = 0; l < LANES; l++) begin
        acc_q[l] <= acc_d[l];
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign act_out   = act_q;

endmodule

// File: tb/tb_psum_accum.sv
module tb_psum_accum;

  localparam int LANES  = 8;
  localparam int PSUM_W = 18;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic [3:0]            num_pass;
  logic [3:0]            shift;
  logic [LANES*8-1:0]    bias_in;
  logic                  psum_valid;
  logic [LANES*PSUM_W-1:0] psum_in;
  logic                  busy;
  logic                  out_valid;
  logic [LANES*4-1:0]    act_out;

  int checks = 0;
  int failures = 0;
  int cycleCnt = 0;
  int lastPsumCycle = 0;
  logic [31:0] expQ [$];
  logic [31:0] expAct;
  logic [PSUM_W-1:0] laneVals [LANES];

  psum_accum #(
    .LANES (LANES),
    .PSUM_W(PSUM_W),
    .ACC_W (24)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_pass  (num_pass),
    .shift     (shift),
    .bias_in   (bias_in),
    .psum_valid(psum_valid),
    .psum_in   (psum_in),
    .busy      (busy),
    .out_valid (out_valid),
    .act_out   (act_out)
  );

  // Free-running clock and cycle counter used for latency measurement.
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Single comparison point: every check funnels through here.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Drives one clock cycle of inputs starting #1 after a rising edge, then
  // drops the strobes. lastPass marks the final pass of a job for latency.
  task automatic applyStimulus(input logic st, input logic [3:0] np, input logic [3:0] sh,
                               input logic [63:0] b, input logic pv,
                               input logic [LANES*PSUM_W-1:0] ps, input logic lastPass);
    start      = st;
    num_pass   = np;
    shift      = sh;
    bias_in    = b;
    psum_valid = pv;
    psum_in    = ps;
    if (lastPass) lastPsumCycle = cycleCnt;
    @(posedge clk);
    #1;
    start      = 1'b0;
    psum_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bounded wait until every expected result has been seen by the monitor.
  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_pending", 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  function automatic logic [LANES*PSUM_W-1:0] allLanes(input logic [PSUM_W-1:0] v);
    return {LANES{v}};
  endfunction

  function automatic logic [LANES*PSUM_W-1:0] packLanes();
    logic [LANES*PSUM_W-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*PSUM_W +: PSUM_W] = laneVals[l];
    return r;
  endfunction

  // Monitor: pops one expected result per out_valid pulse and checks both the
  // activations and the distance from the cycle carrying the final pass.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_out_valid actual=1 expected=0 act_out=%0h", act_out);
      end else begin
        expAct = expQ.pop_front();
        checkOutput("act_out", act_out, expAct);
        checkOutput("latency", 32'(cycleCnt - lastPsumCycle), 32'd2);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b1; start = 1'b0; psum_valid = 1'b0;
    num_pass = '0; shift = '0; bias_in = '0; psum_in = '0;
    #2 rst_n = 1'b0;
    #2;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_act_out", act_out, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idleCycles(1);

    // 1 pass of 5, shift 0; the psum presented with start must be dropped
    expQ.push_back(32'h5555_5555);
    applyStimulus(1'b1, 4'd1, 4'd0, 64'h0, 1'b1, allLanes(18'd9), 1'b0);
    applyStimulus(1'b0, 4'd1, 4'd0, 64'h0, 1'b1, allLanes(18'd5), 1'b1);
    waitDrain();

    // 4 passes of 3, shift 2: 12 -> (12+2)>>2 = 3
    expQ.push_back(32'h3333_3333);
    applyStimulus(1'b1, 4'd4, 4'd2, 64'h0, 1'b0, '0, 1'b0);
    for (int p = 0; p < 4; p++) applyStimulus(1'b0, 4'd4, 4'd2, 64'h0, 1'b1, allLanes(18'd3), p == 3);
    waitDrain();

    // shift 1, lanes 5,-40,7,0,31,30,-1,2 -> 3,0,4,0,15,15,0,1
    laneVals = '{18'd5, -18'sd40, 18'd7, 18'd0, 18'd31, 18'd30, -18'sd1, 18'd2};
    expQ.push_back(32'h10FF_0403);
    applyStimulus(1'b1, 4'd1, 4'd1, 64'h0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 4'd1, 4'd1, 64'h0, 1'b1, packLanes(), 1'b1);
    waitDrain();

    // shift 0 with bias: 1000->15, -3+5=2, 10-3=7, -20+30=10, 15, 16->15, 0, -1->0
    laneVals = '{18'd1000, -18'sd3, 18'd10, -18'sd20, 18'd15, 18'd16, 18'd0, -18'sd1};
    expQ.push_back(32'h00FF_A72F);
    applyStimulus(1'b1, 4'd1, 4'd0, 64'h0000_0000_1EFD_0500, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 4'd1, 4'd0, 64'h0, 1'b1, packLanes(), 1'b1);
    waitDrain();

    // num_pass=0 -> 16 passes of -131072 plus bias -128, no wrap, clamps to 0
    expQ.push_back(32'h0000_0000);
    applyStimulus(1'b1, 4'd0, 4'd0, 64'h8080_8080_8080_8080, 1'b0, '0, 1'b0);
    for (int p = 0; p < 15; p++) applyStimulus(1'b0, 4'd0, 4'd0, 64'h0, 1'b1, allLanes(18'h20000), 1'b0);
    checkOutput("busy_before_16th", 32'(busy), 32'd1);
    applyStimulus(1'b0, 4'd0, 4'd0, 64'h0, 1'b1, allLanes(18'h20000), 1'b1);
    waitDrain();

    // start mid-ACCUM ignored, psums in QUANT/DONE/IDLE ignored: 4+2+1 = 7
    expQ.push_back(32'h7777_7777);
    applyStimulus(1'b1, 4'd2, 4'd0, 64'h0101_0101_0101_0101, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 4'd2, 4'd0, 64'h0, 1'b1, allLanes(18'd4), 1'b0);
    applyStimulus(1'b1, 4'd1, 4'd3, 64'h0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 4'd2, 4'd0, 64'h0, 1'b1, allLanes(18'd2), 1'b1);
    for (int p = 0; p < 3; p++) applyStimulus(1'b0, 4'd1, 4'd0, 64'h0, 1'b1, allLanes(18'd1), 1'b0);
    waitDrain();
    checkOutput("hold_busy", 32'(busy), 32'd0);
    checkOutput("hold_act_out", act_out, 32'h7777_7777);

    // reset after 2 of 4 passes abandons the job and clears act_out
    applyStimulus(1'b1, 4'd4, 4'd0, 64'h0, 1'b0, '0, 1'b0);
    for (int p = 0; p < 2; p++) applyStimulus(1'b0, 4'd4, 4'd0, 64'h0, 1'b1, allLanes(18'd6), 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_act_out", act_out, 32'd0);
    idleCycles(2);
    rst_n = 1'b1;
    idleCycles(3);
    expQ.push_back(32'h7777_7777);
    applyStimulus(1'b1, 4'd1, 4'd0, 64'h0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 4'd1, 4'd0, 64'h0, 1'b1, allLanes(18'd7), 1'b1);
    waitDrain();
    idleCycles(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
